// File: rtl/bot_irq_ctrl_pkg.sv
// Shared constants for the kcpsm6 interrupt controller: register offsets,
// FSM state encoding and VECTOR layout.
package bot_irq_ctrl_pkg;

  localparam logic [7:0] OFF_MASK      = 8'd0;
  localparam logic [7:0] OFF_PEND      = 8'd1;
  localparam logic [7:0] OFF_VECTOR    = 8'd2;
  localparam logic [7:0] OFF_SRC_LEVEL = 8'd3;
  localparam logic [7:0] OFF_EOI       = 8'd4;

  localparam int VEC_VALID_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Byte mask with one bit set for each implemented source.
  function automatic logic [7:0] src_valid_mask(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bot_irq_ctrl_if.sv
// kcpsm6 port-bus and interrupt handshake as seen by the interrupt controller.
interface bot_irq_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic       interrupt_ack;
  logic       interrupt;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (
    output port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    input  interrupt, rd_data, rd_hit
  );

  modport slave (
    input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    output interrupt, rd_data, rd_hit
  );
endinterface

// File: rtl/bot_irq_prio_enc.sv
// Lowest-index-wins priority encoder used to pick the source to service.
module bot_irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [2:0]         id,
  output logic               any
);

  // Scan high to low so the last hit, the lowest index, is kept.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bot_irq_ctrl.sv
// Multi-source edge-triggered interrupt controller driving the kcpsm6 interrupt
// pin, with mask/pending/vector registers on the port bus.
module bot_irq_ctrl
  import bot_irq_ctrl_pkg::*;
#(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  bot_irq_ctrl_if.slave      bus
);

  localparam logic [7:0] SRC_MASK = src_valid_mask(NUM_SRC);

  state_t     state;
  logic [7:0] src_s, src_q, mask_r, pend_r, pend_n;
  logic [7:0] src_in, edge_v, act, off, rd_data_r;
  logic [2:0] active_id, sel_id;
  logic       vec_valid, irq_r, rd_hit_r;
  logic       wr, owned, req, take_ack;
  logic       wr_mask, wr_pend, wr_eoi;

  always_comb begin
    src_in = '0;
    src_in[NUM_SRC-1:0] = irq_src;
  end

  assign edge_v   = src_s & ~src_q;
  assign act      = pend_r & mask_r;
  assign off      = bus.port_id - BASE_ADDR;
  assign owned    = (off <= OFF_EOI);
  assign wr       = bus.write_strobe | bus.k_write_strobe;
  assign wr_mask  = wr && (off == OFF_MASK);
  assign wr_pend  = wr && (off == OFF_PEND);
  assign wr_eoi   = wr && (off == OFF_EOI);
  assign take_ack = (state == ST_ASSERT) && bus.interrupt_ack && req;

  bot_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req (act[NUM_SRC-1:0]),
    .id  (sel_id),
    .any (req)
  );

  // Clears (W1C, ack) are applied first so a coincident edge wins.
  always_comb begin
    pend_n = pend_r;
    if (wr_pend)  pend_n = pend_n & ~bus.out_port;
    if (take_ack) pend_n[sel_id] = 1'b0;
    pend_n = (pend_n | edge_v) & SRC_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_s  <= '0;
      src_q  <= '0;
      mask_r <= '0;
      pend_r <= '0;
    end else begin
      src_s  <= src_in & SRC_MASK;
      src_q  <= src_s;
      pend_r <= pend_n;
      if (wr_mask) mask_r <= bus.out_port & SRC_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      irq_r     <= 1'b0;
      vec_valid <= 1'b0;
      active_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_ASSERT;
            irq_r <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (take_ack) begin
            state     <= ST_SERVICE;
            irq_r     <= 1'b0;
            vec_valid <= 1'b1;
            active_id <= sel_id;
          end else if (!req) begin
            state <= ST_IDLE;
            irq_r <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) begin
            state     <= ST_IDLE;
            vec_valid <= 1'b0;
            active_id <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq_r <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
      rd_hit_r  <= 1'b0;
    end else begin
      rd_hit_r <= owned;
      case (off)
        OFF_MASK:      rd_data_r <= mask_r;
        OFF_PEND:      rd_data_r <= pend_r;
        OFF_VECTOR:    rd_data_r <= {vec_valid, 4'b0000, active_id};
        OFF_SRC_LEVEL: rd_data_r <= src_s;
        default:       rd_data_r <= 8'h00;
      endcase
    end
  end

  assign bus.interrupt = irq_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_hit    = rd_hit_r;

endmodule
